// File: rtl/dcache_wb.sv
`timescale 1ns/1ps
// Direct-mapped, write-back, write-allocate data cache between the core MEM stage
// and word-serial main memory; hits answer combinationally, misses stall via `miss`.
module dcache_wb #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 4,
    parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int SETS  = 1 << SET_ADDR_LEN;
    localparam int WORDS = 1 << LINE_ADDR_LEN;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WB   = 2'd1;
    localparam logic [1:0] FILL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [LINE_ADDR_LEN-1:0] LAST_WORD = '1;

    logic [1:0]                state;
    logic [LINE_ADDR_LEN-1:0]  word_cnt;
    logic [SET_ADDR_LEN-1:0]   miss_set;
    logic [TAG_ADDR_LEN-1:0]   miss_tag;

    logic [SETS-1:0]           valid;
    logic [SETS-1:0]           dirty;
    logic [TAG_ADDR_LEN-1:0]   tag_mem  [SETS];
    logic [31:0]               data_mem [SETS*WORDS];

    logic [LINE_ADDR_LEN-1:0]  req_off;
    logic [SET_ADDR_LEN-1:0]   req_set;
    logic [TAG_ADDR_LEN-1:0]   req_tag;
    logic                      req;
    logic                      hit;
    logic                      store_hit;
    logic [31:0]               hit_word;
    logic                      unused_addr_bits;

    assign req_off = addr[LINE_ADDR_LEN+1:2];
    assign req_set = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign req_tag = addr[31:32-TAG_ADDR_LEN];
    assign unused_addr_bits = ^addr[1:0];

    // Gating with rst keeps miss and rd_data low for the whole reset pulse.
    assign req       = (rd_req | wr_req) & ~rst;
    assign hit       = req & valid[req_set] & (tag_mem[req_set] == req_tag);
    assign store_hit = (state == IDLE) & hit & wr_req;
    assign hit_word  = data_mem[{req_set, req_off}];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        miss      = 1'b0;
        rd_data   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                miss = req & ~hit;
                if (hit) rd_data = hit_word;
            end
            WB: begin
                miss      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_mem[miss_set], miss_set, word_cnt, 2'b00};
                mem_wdata = data_mem[{miss_set, word_cnt}];
            end
            FILL: begin
                miss     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {miss_tag, miss_set, word_cnt, 2'b00};
            end
            default: miss = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            miss_set <= '0;
            miss_tag <= '0;
            valid    <= '0;
            dirty    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (store_hit) begin
                        dirty[req_set] <= 1'b1;
                    end else if (req && !hit) begin
                        miss_set       <= req_set;
                        miss_tag       <= req_tag;
                        word_cnt       <= '0;
                        // The old line is about to be overwritten; a reset mid-transfer leaves it invalid.
                        valid[req_set] <= 1'b0;
                        state          <= (valid[req_set] && dirty[req_set]) ? WB : FILL;
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) state <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) state <= DONE;
                    end
                end
                default: begin
                    valid[miss_set] <= 1'b1;
                    dirty[miss_set] <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

    // NOTE: tag and line storage are not reset; valid bits alone decide whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (state == DONE) tag_mem[miss_set] <= miss_tag;
        if (state == FILL && mem_ack) begin
            data_mem[{miss_set, word_cnt}] <= mem_rdata;
        end else if (store_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) data_mem[{req_set, req_off}][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
`timescale 1ns/1ps
// Self-checking bench for dcache_wb: directed multi-cycle sequences, a table of hit
// vectors, and random traffic checked against a flat-memory reference with a tag model.
module tb_dcache_wb;

    localparam int MEM_WORDS = 4096;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_txn_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_miss;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req, wr_req;
    logic [31:0] addr, wr_data;
    logic [3:0]  wr_be;
    logic [31:0] rd_data;
    logic        miss, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    // Word-serial memory responder state
    logic [31:0] main_mem [MEM_WORDS];
    logic        mem_loaded = 1'b0;
    int          ack_delay  = 0;
    int          wait_cnt   = 0;
    int          unstable   = 0;
    logic        hold_valid = 1'b0;
    logic [64:0] hold_val   = '0;
    mem_txn_t    mem_log [$];

    // Reference model state
    logic [31:0] ref_mem [MEM_WORDS];
    logic        ref_v [16];
    logic        ref_d [16];
    int          ref_t [16];

    dcache_wb dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .addr      (addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_data   (rd_data),
        .miss      (miss),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] byte_addr);
        return {byte_addr[15:0] ^ 16'h5A5A, byte_addr[15:0]};
    endfunction

    // ack_delay 0 ties ack high; otherwise ack comes ack_delay cycles after the word is presented
    assign mem_ack   = (ack_delay == 0) ? 1'b1 : (mem_req && wait_cnt == ack_delay);
    assign mem_rdata = main_mem[mem_addr[13:2]];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < MEM_WORDS; i++) main_mem[i] <= init_word(32'(i * 4));
            mem_loaded <= 1'b1;
        end
        if (rst) begin
            wait_cnt   <= 0;
            hold_valid <= 1'b0;
        end else begin
            if (mem_req && mem_ack) begin
                mem_log.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
                if (mem_we) main_mem[mem_addr[13:2]] <= mem_wdata;
                wait_cnt <= 0;
            end else if (mem_req) begin
                wait_cnt <= wait_cnt + 1;
            end else begin
                wait_cnt <= 0;
            end
            if (mem_req) begin
                if (hold_valid && hold_val != {mem_we, mem_addr, mem_wdata}) unstable <= unstable + 1;
                hold_val   <= {mem_we, mem_addr, mem_wdata};
                hold_valid <= !mem_ack;
            end else begin
                hold_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one request, counts miss cycles until the hit, returns rd_data of the hit cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          output int cycles, output logic [31:0] rdata);
        @(negedge clk);
        rd_req = rd; wr_req = wr; addr = a; wr_data = d; wr_be = be;
        cycles = 0;
        #1;
        while (miss === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        if (cycles >= 200) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: addr %h still missing after %0d cycles", a, cycles);
        end
        rdata = rd_data;
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    initial begin
        int          cyc, base, n;
        logic [31:0] rdata;
        vec_t        vecs [$];

        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        addr = '0; wr_data = '0; wr_be = '0;
        repeat (3) @(negedge clk);

        // Reset state (request asserted so the rst gating of miss is exercised)
        rd_req = 1'b1; addr = 32'h100;
        #1;
        check("rst_miss", miss, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Clean miss with ack tied high
        base = mem_log.size();
        access(1, 0, 32'h100, 0, 0, cyc, rdata);
        check("fill_miss_cycles", cyc, 10);
        check("fill_rdata", rdata, init_word(32'h100));
        check("fill_txn_count", mem_log.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            check("fill_addr", mem_log[base+i].addr, 32'h100 + 32'(4 * i));
            check("fill_we", mem_log[base+i].we, 0);
        end

        // Store hits
        base = mem_log.size();
        access(0, 1, 32'h104, 32'hDEADBEEF, 4'hF, cyc, rdata);
        check("store_miss_cycles", cyc, 0);
        check("store_no_mem_txn", mem_log.size() - base, 0);
        access(1, 0, 32'h104, 0, 0, cyc, rdata);
        check("store_readback", rdata, 32'hDEADBEEF);
        access(0, 1, 32'h104, 32'h0000AB00, 4'b0010, cyc, rdata);
        access(1, 0, 32'h104, 0, 0, cyc, rdata);
        check("byte_merge", rdata, 32'hDEADABEF);

        // Dirty conflict miss: write back then refill
        base = mem_log.size();
        access(1, 0, 32'h300, 0, 0, cyc, rdata);
        check("dirty_miss_cycles", cyc, 18);
        check("dirty_txn_count", mem_log.size() - base, 16);
        check("dirty_rdata", rdata, init_word(32'h300));
        for (int i = 0; i < 8; i++) begin
            check("wb_we", mem_log[base+i].we, 1);
            check("wb_addr", mem_log[base+i].addr, 32'h100 + 32'(4 * i));
            check("wb_data", mem_log[base+i].data,
                  (i == 1) ? 32'hDEADABEF : init_word(32'h100 + 32'(4 * i)));
            check("refill_we", mem_log[base+8+i].we, 0);
            check("refill_addr", mem_log[base+8+i].addr, 32'h300 + 32'(4 * i));
        end

        // Single-cycle hit vectors on the resident 0x300 line
        vecs.push_back('{rd: 1, wr: 0, addr: 32'h304, data: 0, be: 0, exp_rd: init_word(32'h304), exp_miss: 0});
        vecs.push_back('{rd: 0, wr: 1, addr: 32'h308, data: 32'h11223344, be: 4'hF, exp_rd: init_word(32'h308), exp_miss: 0});
        vecs.push_back('{rd: 1, wr: 0, addr: 32'h308, data: 0, be: 0, exp_rd: 32'h11223344, exp_miss: 0});
        vecs.push_back('{rd: 0, wr: 1, addr: 32'h308, data: 32'hAABBCCDD, be: 4'b1001, exp_rd: 32'h11223344, exp_miss: 0});
        vecs.push_back('{rd: 1, wr: 0, addr: 32'h308, data: 0, be: 0, exp_rd: 32'hAA2233DD, exp_miss: 0});
        vecs.push_back('{rd: 1, wr: 1, addr: 32'h30C, data: 32'h55667788, be: 4'b0100, exp_rd: init_word(32'h30C), exp_miss: 0});
        vecs.push_back('{rd: 1, wr: 0, addr: 32'h30C, data: 0, be: 0,
                         exp_rd: (init_word(32'h30C) & 32'hFF00FFFF) | 32'h00660000, exp_miss: 0});
        vecs.push_back('{rd: 0, wr: 0, addr: 32'h308, data: 0, be: 0, exp_rd: 0, exp_miss: 0});
        vecs.push_back('{rd: 0, wr: 1, addr: 32'h31C, data: 32'hFFFFFFFF, be: 4'h0, exp_rd: init_word(32'h31C), exp_miss: 0});
        vecs.push_back('{rd: 1, wr: 0, addr: 32'h31C, data: 0, be: 0, exp_rd: init_word(32'h31C), exp_miss: 0});
        foreach (vecs[i]) begin
            @(negedge clk);
            rd_req = vecs[i].rd; wr_req = vecs[i].wr; addr = vecs[i].addr;
            wr_data = vecs[i].data; wr_be = vecs[i].be;
            #1;
            check($sformatf("vec%0d_miss", i), miss, vecs[i].exp_miss);
            check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd);
        end
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;

        // Clean miss with slow memory: ack three cycles after each word is presented
        ack_delay = 3;
        base = mem_log.size();
        access(1, 0, 32'h2040, 0, 0, cyc, rdata);
        check("slow_miss_cycles", cyc, 34);
        check("slow_txn_count", mem_log.size() - base, 8);
        check("slow_addr_stable", unstable, 0);
        check("slow_rdata", rdata, init_word(32'h2040));
        ack_delay = 0;

        // Reset in the middle of a refill, at word 4
        @(negedge clk);
        rd_req = 1'b1; addr = 32'h0A0;
        base = mem_log.size();
        n = 0;
        while (mem_log.size() - base < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_word4", mem_log.size() - base, 4);
        #1 rst = 1'b1;
        #1;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_miss", miss, 0);
        rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        base = mem_log.size();
        access(1, 0, 32'h0A0, 0, 0, cyc, rdata);
        check("postrst_miss_cycles", cyc, 10);
        check("postrst_txn_count", mem_log.size() - base, 8);
        check("postrst_first_addr", mem_log[base].addr, 32'h0A0);
        check("postrst_rdata", rdata, init_word(32'h0A0));

        // Random traffic against a flat memory plus tag model
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = main_mem[i];
        for (int s = 0; s < 16; s++) begin
            ref_v[s] = 1'b0; ref_d[s] = 1'b0; ref_t[s] = 0;
        end
        for (int k = 0; k < 150; k++) begin
            int          tg, st, of, kind, exp_cyc, idx;
            logic        rd, wr;
            logic [31:0] a, d;
            logic [3:0]  be;
            tg   = int'($urandom_range(0, 2));
            st   = int'($urandom_range(0, 3));
            of   = int'($urandom_range(0, 7));
            kind = int'($urandom_range(0, 9));
            a    = 32'(tg * 512 + st * 32 + of * 4);
            d    = $urandom;
            be   = 4'($urandom_range(0, 15));
            rd   = (kind < 5) || (kind == 9);
            wr   = (kind >= 5);
            ack_delay = int'($urandom_range(0, 1));
            if (ref_v[st] && ref_t[st] == tg) exp_cyc = 0;
            else exp_cyc = 2 + ((ref_v[st] && ref_d[st]) ? 16 : 8) * (ack_delay + 1);
            idx = int'(a[13:2]);
            access(rd, wr, a, d, be, cyc, rdata);
            check("rand_miss_cycles", cyc, exp_cyc);
            check("rand_rd_data", rdata, ref_mem[idx]);
            if (exp_cyc != 0) begin
                ref_v[st] = 1'b1; ref_t[st] = tg; ref_d[st] = 1'b0;
            end
            if (wr) begin
                ref_d[st] = 1'b1;
                for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
        check("rand_addr_stable", unstable, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
